id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage that sits directly upstream of RegFile.
- Accepts fetched RV32I instructions over a valid/ready handshake and decodes the fields.
- Drives RegFile read addresses (rs1/rs2/readEn) and captures readOut1/readOut2 into an ID/EX pipeline register.
- A 32-entry scoreboard stalls RAW hazards until writeback clears the destination register.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers (scoreboard depth).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch holds a valid instruction
- in_ready  output  1  stage accepts the instruction this cycle
- in_instr  input  32  instruction word
- in_pc  input  32  instruction PC
- rs1  output  5  RegFile read address 1 (instr[19:15])
- rs2  output  5  RegFile read address 2 (instr[24:20])
- readEn  output  1  RegFile read enable, equal to in_valid
- readOut1  input  32  RegFile read data 1, combinational from rs1
- readOut2  input  32  RegFile read data 2, combinational from rs2
- wb_valid  input  1  writeback retiring a register write
- wb_rd  input  5  register being written back
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  execute consumes the instruction
- out_pc  output  32  registered PC
- out_op1  output  32  registered rs1 value
- out_op2  output  32  registered rs2 value
- out_imm  output  32  registered sign-extended immediate
- out_rd  output  5  registered destination register
- out_wen  output  1  instruction writes rd (forced 0 when rd==0)
- out_opcode  output  7  registered opcode
- out_funct3  output  3  registered funct3
- out_funct7b  output  1  registered instr[30]
- out_illegal  output  1  registered unknown-opcode flag

Behaviour:
- Reset (reset==0, asynchronous): all out_* = 0, scoreboard busy[31:0] = 0. Outputs stay 0 until reset deasserts.
- Decode is purely combinational from in_instr. Register use by opcode:
  - rs1 used: R, I, S, B, LOAD, JALR.
  - rs2 used: R, S, B.
  - rd written: R, I, LOAD, JALR, JAL, LUI, AUIPC.
- Immediate formats, sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type: imm = 0.
- Hazard: hazard = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]). busy[0] is always 0.
- in_ready = ~hazard & (~out_valid | out_ready).
- Issue (fire = in_valid & in_ready), on the next edge:
  - the ID/EX register loads the decoded fields plus readOut1/readOut2;
  - out_valid becomes 1;
  - busy[rd] is set if out_wen.
- Drain: if out_valid & out_ready & ~fire, out_valid becomes 0 next edge; other out_* hold.
- Backpressure: out_valid & ~out_ready holds the register stable and in_ready = 0.
- Writeback: wb_valid clears busy[wb_rd] next edge. The clear is not visible to hazard in the same cycle, so one stall cycle after the clear is guaranteed.
- Simultaneous set and clear of the same register: set wins, because the newly issued producer is younger.
- wb_valid with wb_rd==0 has no effect.
- Illegal opcode: out_illegal = 1, out_wen = 0, no scoreboard update, instruction still issues.
- Latency: 1 cycle in_valid to out_valid when no hazard. Throughput is 1 instruction/cycle with out_ready held high.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants (OP_R=0110011, OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111);
  - an imm-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- Sub-module imm_gen (combinational: instr, format -> imm).

Test Plan:
- Reset mid-stream with out_valid=1 and busy[1]=1 -> out_valid=0 and busy all 0 immediately; after release, ADDI x1 issues without stall.
- ADDI x1,x0,-1 (0xFFF00093), readOut1=0, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=1, out_wen=1, busy[1]=1.
- ADD x2,x1,x1 (0x00108133) right after ADDI x1 -> in_ready=0. Then wb_valid=1, wb_rd=1 -> in_ready=1 one cycle after the clear edge; out_op1/out_op2 capture readOut values.
- LUI x3,0x12345 (0x123451B7) -> out_imm=0x12345000, no stall. ADDI x0,x0,0 (0x00000013) -> out_wen=0, busy[0] stays 0.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; raising out_ready issues the pending in_instr that cycle.
- Opcode 1111111 (0x0000007F) -> out_illegal=1, out_wen=0. Same-cycle issue of ADDI x1 with wb_valid, wb_rd=1 -> busy[1]=1 afterwards.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I opcode constants, immediate-format enum and the per-opcode decode table
// shared by the decode stage and its immediate generator.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic     use_rs1;
        logic     use_rs2;
        logic     rd_we;
        logic     illegal;
        imm_fmt_t fmt;
    } decode_t;

    // Register usage and immediate layout per opcode; unknown opcodes use nothing.
    function automatic decode_t decode_op(input logic [6:0] opcode);
        decode_t d;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        d.rd_we   = 1'b0;
        d.illegal = 1'b0;
        d.fmt     = IMM_NONE;
        case (opcode)
            OP_R: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.rd_we   = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                d.use_rs1 = 1'b1;
                d.rd_we   = 1'b1;
                d.fmt     = IMM_I;
            end
            OP_STORE: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.fmt     = IMM_S;
            end
            OP_BRANCH: begin
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                d.fmt     = IMM_B;
            end
            OP_JAL: begin
                d.rd_we = 1'b1;
                d.fmt   = IMM_J;
            end
            OP_LUI, OP_AUIPC: begin
                d.rd_we = 1'b1;
                d.fmt   = IMM_U;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; every format sign-extends from instr[31].
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{21{instr[31]}}, instr[30:20]};
            IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: reads RegFile operands, tracks in-flight destinations in a
// scoreboard to stall RAW hazards, and holds the result in an ID/EX register.
module id_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            readEn,
    input  logic [XLEN-1:0] readOut1,
    input  logic [XLEN-1:0] readOut2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b,
    output logic            out_illegal
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits on ready, and a held valid keeps its payload stable.

    decode_t          dec;
    logic [4:0]       rd;
    logic             wen;
    logic [31:0]      imm;
    logic             hazard;
    logic             fire;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    assign dec    = decode_op(in_instr[6:0]);
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rd     = in_instr[11:7];
    assign readEn = in_valid;
    assign wen    = dec.rd_we & (rd != 5'd0);

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (dec.fmt),
        .imm   (imm)
    );

    assign hazard   = (dec.use_rs1 & busy[rs1]) | (dec.use_rs2 & busy[rs2]);
    assign in_ready = ~hazard & (~out_valid | out_ready);
    assign fire     = in_valid & in_ready;

    // Set after clear so a producer issuing alongside an older writeback keeps rd busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (fire && wen) begin
            busy_nxt[rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7b <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (fire) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_op1     <= readOut1;
                out_op2     <= readOut2;
                out_imm     <= imm;
                out_rd      <= rd;
                out_wen     <= wen;
                out_opcode  <= in_instr[6:0];
                out_funct3  <= in_instr[14:12];
                out_funct7b <= in_instr[30];
                out_illegal <= dec.illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a behavioural RegFile, a reference decoder feeding an
// expected queue at issue time, and per-scenario tasks with inline checks.
`timescale 1ns/1ps
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        readEn;
    logic [31:0] readOut1;
    logic [31:0] readOut2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;
    logic [31:0]  salt;
    logic [145:0] exp_q[$];
    logic [145:0] obs;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1(rs1), .rs2(rs2), .readEn(readEn), .readOut1(readOut1), .readOut2(readOut2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
        .out_wen(out_wen), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b(out_funct7b), .out_illegal(out_illegal)
    );

    // Behavioural RegFile: x0 reads zero, others a salted pattern.
    assign readOut1 = (rs1 == 5'd0) ? 32'd0 : (({27'd0, rs1} * 32'h0101_0101) ^ salt);
    assign readOut2 = (rs2 == 5'd0) ? 32'd0 : (({27'd0, rs2} * 32'h0101_0101) ^ salt);

    function automatic logic [31:0] rf_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        return ({27'd0, r} * 32'h0101_0101) ^ salt;
    endfunction

    function automatic logic [145:0] ref_exp(input logic [31:0] i, input logic [31:0] pc);
        logic [31:0] imm;
        logic [31:0] sx;
        logic        legal;
        logic        writes;
        sx     = $signed(i) >>> 20;
        legal  = 1'b1;
        writes = 1'b0;
        imm    = 32'd0;
        case (i[6:0])
            7'h33: writes = 1'b1;
            7'h13, 7'h03, 7'h67: begin writes = 1'b1; imm = sx; end
            7'h23: imm = {sx[31:5], i[11:7]};
            7'h63: imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: begin writes = 1'b1; imm = {i[31:12], 12'h000}; end
            7'h6F: begin writes = 1'b1; imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
            default: legal = 1'b0;
        endcase
        return {pc, rf_val(i[19:15]), rf_val(i[24:20]), imm, i[11:7],
                writes && legal && (i[11:7] != 5'd0), i[6:0], i[14:12], i[30], ~legal};
    endfunction

    assign obs = {out_pc, out_op1, out_op2, out_imm, out_rd, out_wen, out_opcode,
                  out_funct3, out_funct7b, out_illegal};

    // Scoreboard: pop a consumed beat before pushing the one accepted this cycle.
    always @(negedge clk) begin
        if (reset) begin
            total++;
            if (readEn !== in_valid) begin
                bad++;
                $display("FAIL readen got=%b want=%b", readEn, in_valid);
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%h want=none", obs);
                end else begin
                    logic [145:0] e;
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        bad++;
                        $display("FAIL out_fields got=%h want=%h", obs, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                total++;
                if ({rs1, rs2} !== {in_instr[19:15], in_instr[24:20]}) begin
                    bad++;
                    $display("FAIL rs_addr got=%h/%h want=%h/%h", rs1, rs2, in_instr[19:15], in_instr[24:20]);
                end
                exp_q.push_back(ref_exp(in_instr, in_pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        int n;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=stalled want=accept instr=%h", instr);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({out_valid, obs} !== 147'd0) begin
            bad++;
            $display("FAIL reset_out got=%h want=0", {out_valid, obs});
        end
        total++;
        if (dut.busy !== 32'd0) begin
            bad++;
            $display("FAIL reset_busy got=%h want=0", dut.busy);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset got=%b%b want=01", out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_addi();
        send(32'hFFF0_0093, 32'h100);
        @(negedge clk);
        total++;
        if ({out_valid, out_imm, out_rd, out_wen} !== {1'b1, 32'hFFFF_FFFF, 5'd1, 1'b1}) begin
            bad++;
            $display("FAIL addi got=%b %h %0d %b want=1 ffffffff 1 1", out_valid, out_imm, out_rd, out_wen);
        end
        total++;
        if (dut.busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL addi_busy got=%b want=1", dut.busy[1]);
        end
        tick();
    endtask

    task automatic test_raw();
        in_valid = 1'b1;
        in_instr = 32'h0010_8133;
        in_pc    = 32'h104;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL raw_stall got=%b want=0 cycle=%0d", in_ready, k);
            end
            tick();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL raw_wb_cycle got=%b want=0", in_ready);
        end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || dut.busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL raw_release got=%b busy1=%b want=1 0", in_ready, dut.busy[1]);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_op1, out_op2, out_rd} !== {rf_val(5'd1), rf_val(5'd1), 5'd2} || dut.busy[2] !== 1'b1) begin
            bad++;
            $display("FAIL raw_ops got=%h %h %0d want=%h %h 2", out_op1, out_op2, out_rd, rf_val(5'd1), rf_val(5'd1));
        end
        tick();
    endtask

    task automatic test_lui_x0();
        in_valid = 1'b1;
        in_instr = 32'h1234_51B7;
        in_pc    = 32'h108;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL lui_ready got=%b want=1", in_ready);
        end
        tick();
        in_instr = 32'h0000_0013;
        in_pc    = 32'h10C;
        @(negedge clk);
        total++;
        if ({out_imm, out_rd, in_ready} !== {32'h1234_5000, 5'd3, 1'b1}) begin
            bad++;
            $display("FAIL lui got=%h %0d %b want=12345000 3 1", out_imm, out_rd, in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_wen, out_rd, dut.busy[0]} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL nop got=%b %b %0d %b want=1 0 0 0", out_valid, out_wen, out_rd, dut.busy[0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0050_0293;
        in_pc     = 32'h200;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first got=%b want=1", in_ready);
        end
        tick();
        in_instr = 32'h0060_0313;
        in_pc    = 32'h204;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_rd, out_imm, out_pc, in_ready} !== {1'b1, 5'd5, 32'd5, 32'h200, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold got=%b %0d %h %h %b want=1 5 5 200 0", out_valid, out_rd, out_imm, out_pc, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd6, 32'h204}) begin
            bad++;
            $display("FAIL bp_next got=%b %0d %h want=1 6 204", out_valid, out_rd, out_pc);
        end
        tick();
    endtask

    task automatic test_illegal();
        send(32'h0000_0FFF, 32'h300);
        @(negedge clk);
        total++;
        if ({out_illegal, out_wen, out_opcode, dut.busy[31]} !== {1'b1, 1'b0, 7'h7F, 1'b0}) begin
            bad++;
            $display("FAIL illegal got=%b %b %h %b want=1 0 7f 0", out_illegal, out_wen, out_opcode, dut.busy[31]);
        end
        tick();
    endtask

    task automatic test_set_clear();
        send(32'hFFF0_0093, 32'h304);
        in_valid = 1'b1;
        in_instr = 32'hFFF0_0093;
        in_pc    = 32'h308;
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL setclr_ready got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        wb_rd    = 5'd0;
        @(negedge clk);
        total++;
        if (dut.busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins got=%b want=1", dut.busy[1]);
        end
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({dut.busy[1], dut.busy[0]} !== 2'b10) begin
            bad++;
            $display("FAIL wb_x0 got=%b want=10", {dut.busy[1], dut.busy[0]});
        end
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dut.busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL wb_clear got=%b want=0", dut.busy[1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[9];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        salt      = $urandom;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 8)];
            w[19:15] = 5'd0;
            w[24:20] = 5'd0;
            in_valid = 1'b1;
            in_instr = w;
            in_pc    = 32'h500 + 32'(k * 4);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready got=%b want=1 k=%0d instr=%h", in_ready, k, w);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'hFFF0_0093, 32'h400);
        @(negedge clk);
        total++;
        if ({out_valid, dut.busy[1]} !== 2'b11) begin
            bad++;
            $display("FAIL mid_pre got=%b want=11", {out_valid, dut.busy[1]});
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, obs} !== 147'd0 || dut.busy !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b busy=%h want=0 0", out_valid, dut.busy);
        end
        exp_q.delete();
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF0_0093;
        in_pc     = 32'h404;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_after got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_rd} !== {1'b1, 5'd1}) begin
            bad++;
            $display("FAIL mid_issue got=%b %0d want=1 1", out_valid, out_rd);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        salt      = $urandom;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_raw();
        test_lui_x0();
        test_backpressure();
        test_illegal();
        test_set_clear();
        test_back_to_back();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
